cmd_sequence_player: RTL

Read-side executor for the robot's stored direction-command list. On a start pulse it reads N 2-bit commands from the command RAM through a synchronous read port. It holds each command for a fixed dwell time and drives the direction glyph on HEX0-HEX3 and the torque pattern on LEDR. It sits between the command RAM (written by the programming front-end) and the board display/LED outputs.

---
 rtl/cmd_sequence_player.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/cmd_sequence_player.sv
// cmd_sequence_player: plays back a stored list of 2-bit direction commands.
// Each command is fetched from a synchronous-read RAM and shown on the 7-seg
// digits and LEDs for DELAY_CYCLES cycles. The fetch and latch cycles add two
// more cycles, so each command takes DELAY_CYCLES+2 cycles in total.
module cmd_sequence_player #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DELAY_CYCLES = 50_000_000,
  parameter int unsigned TMR_W        = $clog2(DELAY_CYCLES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   cmd_count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_index,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX3,
  output logic [17:0]       LEDR
);

  // DELAY_CYCLES=1 gives a zero-width timer; keep at least one bit
  localparam int unsigned TW = (TMR_W < 1) ? 1 : TMR_W;
  localparam logic [TW-1:0] TMR_LAST = TW'(DELAY_CYCLES - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_B     = 7'b0000011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            state, state_n;
  // idx and count carry one extra bit so a full 256-entry list never wraps
  logic [ADDR_W:0]   idx, idx_n, idx_inc;
  logic [ADDR_W:0]   count, count_n;
  logic [TW-1:0]     timer, timer_n;
  logic              rd_en_n;
  logic [ADDR_W-1:0] rd_addr_n;
  logic [ADDR_W-1:0] cur_index_n;
  logic [6:0]        hex0_n, hex1_n, hex2_n, hex3_n;
  logic [17:0]       ledr_n;

  assign busy = (state == S_FETCH) || (state == S_LATCH) || (state == S_HOLD);
  assign done = (state == S_DONE);

  // State and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      count     <= '0;
      timer     <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      cur_index <= '0;
      HEX0      <= SEG_BLANK;
      HEX1      <= SEG_BLANK;
      HEX2      <= SEG_BLANK;
      HEX3      <= SEG_BLANK;
      LEDR      <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      count     <= count_n;
      timer     <= timer_n;
      rd_en     <= rd_en_n;
      rd_addr   <= rd_addr_n;
      cur_index <= cur_index_n;
      HEX0      <= hex0_n;
      HEX1      <= hex1_n;
      HEX2      <= hex2_n;
      HEX3      <= hex3_n;
      LEDR      <= ledr_n;
    end
  end

  // Next-state and next-output logic; rd_en is set on entry to FETCH so it
  // is high for exactly the FETCH cycle
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    count_n     = count;
    timer_n     = timer;
    rd_en_n     = 1'b0;
    rd_addr_n   = rd_addr;
    cur_index_n = cur_index;
    hex0_n      = HEX0;
    hex1_n      = HEX1;
    hex2_n      = HEX2;
    hex3_n      = HEX3;
    ledr_n      = LEDR;
    idx_inc     = idx + 1'b1;

    if (abort) begin
      state_n = S_IDLE;
      hex0_n  = SEG_BLANK;
      hex1_n  = SEG_BLANK;
      hex2_n  = SEG_BLANK;
      hex3_n  = SEG_BLANK;
      ledr_n  = '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (cmd_count == '0) begin
              state_n = S_DONE;
            end else begin
              state_n   = S_FETCH;
              count_n   = cmd_count;
              idx_n     = '0;
              rd_en_n   = 1'b1;
              rd_addr_n = '0;
            end
          end
        end
        S_FETCH: begin
          state_n = S_LATCH;
        end
        S_LATCH: begin
          state_n     = S_HOLD;
          timer_n     = '0;
          cur_index_n = idx[ADDR_W-1:0];
          hex0_n      = SEG_BLANK;
          hex1_n      = SEG_BLANK;
          hex2_n      = SEG_BLANK;
          hex3_n      = SEG_BLANK;
          case (rd_data)
            2'b00: begin hex2_n = SEG_F; ledr_n = 18'h00F0F; end
            2'b01: begin hex0_n = SEG_R; ledr_n = 18'h00F0C; end
            2'b10: begin hex1_n = SEG_L; ledr_n = 18'h00C0F; end
            default: begin hex3_n = SEG_B; ledr_n = 18'h0F0F0; end
          endcase
        end
        S_HOLD: begin
          timer_n = timer + 1'b1;
          if (timer == TMR_LAST) begin
            if (idx == count - 1'b1) begin
              state_n = S_DONE;
              hex0_n  = SEG_BLANK;
              hex1_n  = SEG_BLANK;
              hex2_n  = SEG_BLANK;
              hex3_n  = SEG_BLANK;
              ledr_n  = '0;
            end else begin
              state_n   = S_FETCH;
              idx_n     = idx_inc;
              rd_en_n   = 1'b1;
              rd_addr_n = idx_inc[ADDR_W-1:0];
            end
          end
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

endmodule
